// File: rtl/spike_pkg.sv
// Shared types and defaults for the axon spike collector.
// FSM state encoding, size defaults and the frame length clamp.
package spike_pkg;

   localparam int DEF_NUM_AXONS       = 256;
   localparam int DEF_AXON_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      HOLD
   } state_e;

   // Zero or oversize lengths mean a full-width frame.
   function automatic int clamp_len(input int len, input int n);
      return ((len == 0) || (len > n)) ? n : len;
   endfunction

endpackage

// File: rtl/spike_axon_collector.sv
// Deserializes crossbar axon spikes into a double-buffered parallel vector.
// Optional per-frame popcount output enabled by SPIKE_COUNT_EN.
module spike_axon_collector
   import spike_pkg::*;
#(
   parameter int NUM_AXONS       = DEF_NUM_AXONS,
   parameter int AXON_ADDR_WIDTH = DEF_AXON_ADDR_WIDTH
) (
   input  logic                     clk,
   input  logic                     rstb,
   input  logic                     start,
   input  logic [AXON_ADDR_WIDTH:0] frame_len,
   input  logic                     spike_valid,
   input  logic                     spike_in,
   output logic [NUM_AXONS-1:0]     axon_out,
   output logic                     axon_valid,
   input  logic                     axon_ready,
   output logic                     busy,
   output logic                     overflow,
   input  logic                     clr_err
`ifdef SPIKE_COUNT_EN
   ,
   output logic [AXON_ADDR_WIDTH:0] spike_count
`endif
);

   localparam int AW1 = AXON_ADDR_WIDTH + 1;
   localparam logic [AXON_ADDR_WIDTH:0] ONE = AW1'(1);

   state_e r_state;
   state_e w_state_nxt;

   logic [NUM_AXONS-1:0]     r_shadow;
   logic [NUM_AXONS-1:0]     w_shadow_wr;
   logic [NUM_AXONS-1:0]     r_axon;
   logic [AXON_ADDR_WIDTH:0] r_idx;
   logic [AXON_ADDR_WIDTH:0] r_len;
   logic [AXON_ADDR_WIDTH:0] w_len;
   logic                     r_valid;
   logic                     r_ovf;

   logic w_hs;
   logic w_open;
   logic w_wr;
   logic w_last;
   logic w_slot_free;
   logic w_to_out;
   logic w_drop;

   assign w_len       = AW1'(clamp_len(int'(frame_len), NUM_AXONS));
   assign w_hs        = r_valid & axon_ready;
   assign w_open      = start & (r_state != HOLD);
   assign w_wr        = (r_state == COLLECT) & spike_valid & ~start;
   assign w_last      = w_wr & ((r_idx + ONE) == r_len);
   assign w_slot_free = ~r_valid | axon_ready;
   assign w_drop      = spike_valid & (r_state != COLLECT);
   assign w_to_out    = (w_last & w_slot_free)
                      | ((r_state == HOLD) & w_hs);

   // Shadow with the current spike merged in, so the last bit
   // can be delivered on the same edge it is sampled.
   always_comb begin
      w_shadow_wr = r_shadow;
      w_shadow_wr[r_idx[AXON_ADDR_WIDTH-1:0]] = spike_in;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = COLLECT;
         COLLECT: begin
            if (w_last) w_state_nxt = w_slot_free ? IDLE : HOLD;
         end
         HOLD:    if (w_hs) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_shadow <= '0;
         r_idx    <= '0;
         r_len    <= '0;
         r_axon   <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_open) begin
            r_shadow <= '0;
            r_idx    <= '0;
            r_len    <= w_len;
         end else if (w_wr) begin
            r_shadow <= w_shadow_wr;
            r_idx    <= r_idx + ONE;
         end
         if (w_to_out) begin
            r_axon  <= (r_state == HOLD) ? r_shadow : w_shadow_wr;
            r_valid <= 1'b1;
         end else if (w_hs) begin
            r_valid <= 1'b0;
         end
         if (w_drop)       r_ovf <= 1'b1;
         else if (clr_err) r_ovf <= 1'b0;
      end
   end

`ifdef SPIKE_COUNT_EN
   logic [AXON_ADDR_WIDTH:0] r_cnt_sh;
   logic [AXON_ADDR_WIDTH:0] r_cnt_out;
   logic [AXON_ADDR_WIDTH:0] w_cnt_wr;

   assign w_cnt_wr = r_cnt_sh + AW1'(spike_in);

   always_ff @(posedge clk) begin
      if (!rstb) begin
         r_cnt_sh  <= '0;
         r_cnt_out <= '0;
      end else begin
         if (w_open)    r_cnt_sh <= '0;
         else if (w_wr) r_cnt_sh <= w_cnt_wr;
         if (w_to_out) begin
            r_cnt_out <= (r_state == HOLD) ? r_cnt_sh : w_cnt_wr;
         end
      end
   end

   assign spike_count = r_cnt_out;
`endif

   assign axon_out   = r_axon;
   assign axon_valid = r_valid;
   assign busy       = (r_state != IDLE);
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_spike_axon_collector.sv
// Self-checking bench for spike_axon_collector: directed scenarios
// plus randomized frames under random backpressure.
module tb_spike_axon_collector;

   localparam int N  = 256;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rstb = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   frame_len = '0;
   logic          spike_valid = 1'b0;
   logic          spike_in = 1'b0;
   logic [N-1:0]  axon_out;
   logic          axon_valid;
   logic          axon_ready = 1'b0;
   logic          busy;
   logic          overflow;
   logic          clr_err = 1'b0;
`ifdef SPIKE_COUNT_EN
   logic [AW:0]   spike_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   logic         mon_en = 1'b0;
   logic         prev_stall = 1'b0;
   logic [N-1:0] prev_out = '0;
   logic [N-1:0] exp_q[$];

   spike_axon_collector dut (
      .clk        (clk),
      .rstb       (rstb),
      .start      (start),
      .frame_len  (frame_len),
      .spike_valid(spike_valid),
      .spike_in   (spike_in),
      .axon_out   (axon_out),
      .axon_valid (axon_valid),
      .axon_ready (axon_ready),
      .busy       (busy),
      .overflow   (overflow),
      .clr_err    (clr_err)
`ifdef SPIKE_COUNT_EN
      ,
      .spike_count(spike_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [AW:0] fl,
                             input logic [N-1:0] bits,
                             input int nsp);
      start = 1'b1;
      frame_len = fl;
      tick();
      start = 1'b0;
      for (int i = 0; i < nsp; i++) begin
         spike_valid = 1'b1;
         spike_in = bits[i];
         tick();
      end
      spike_valid = 1'b0;
      spike_in = 1'b0;
   endtask

   // Handshake scoreboard and output stability under backpressure.
   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            n_cmp++;
            if (!axon_valid || axon_out !== prev_out) begin
               n_err++;
               $display("FAIL stall_stable got v=%0b %h want %h",
                        axon_valid, axon_out, prev_out);
            end
         end
         if (axon_valid && axon_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL rand_extra got %h want none", axon_out);
            end else begin
               logic [N-1:0] e;
               e = exp_q.pop_front();
               if (axon_out !== e) begin
                  n_err++;
                  $display("FAIL rand_vec got %h want %h", axon_out, e);
               end
`ifdef SPIKE_COUNT_EN
               n_cmp++;
               if (spike_count !== (AW+1)'($countones(e))) begin
                  n_err++;
                  $display("FAIL rand_cnt got %0d want %0d",
                           spike_count, $countones(e));
               end
`endif
            end
         end
         prev_stall = axon_valid && !axon_ready;
         prev_out = axon_out;
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic test_reset();
      rstb = 1'b0;
      tick();
      tick();
      n_cmp++;
      if (axon_out !== '0 || axon_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out got v=%0b %h want 0", axon_valid, axon_out);
      end
      n_cmp++;
      if (busy !== 1'b0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL reset_flags got b=%0b o=%0b want 0 0", busy, overflow);
      end
`ifdef SPIKE_COUNT_EN
      n_cmp++;
      if (spike_count !== '0) begin
         n_err++;
         $display("FAIL reset_cnt got %0d want 0", spike_count);
      end
`endif
      rstb = 1'b1;
      tick();
   endtask

   task automatic test_full_frame();
      logic [N-1:0] bits;
      logic [N-1:0] want;
      for (int i = 0; i < N; i++) bits[i] = (i % 2 == 0);
      want = {64{4'h5}};
      axon_ready = 1'b1;
      send_frame('0, bits, N);
      n_cmp++;
      if (axon_valid !== 1'b1 || axon_out !== want) begin
         n_err++;
         $display("FAIL full_vec got v=%0b %h want 1 %h",
                  axon_valid, axon_out, want);
      end
`ifdef SPIKE_COUNT_EN
      n_cmp++;
      if (spike_count !== 9'd128) begin
         n_err++;
         $display("FAIL full_cnt got %0d want 128", spike_count);
      end
`endif
      tick();
      n_cmp++;
      if (axon_valid !== 1'b0) begin
         n_err++;
         $display("FAIL full_consumed got %0b want 0", axon_valid);
      end
   endtask

   task automatic test_short_frame();
      axon_ready = 1'b1;
      send_frame(9'd4, 256'b1101, 4);
      n_cmp++;
      if (axon_out !== 256'hD || axon_valid !== 1'b1) begin
         n_err++;
         $display("FAIL short_vec got v=%0b %h want 1 d", axon_valid, axon_out);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL short_busy got %0b want 0", busy);
      end
      tick();
   endtask

   task automatic test_backpressure();
      axon_ready = 1'b0;
      send_frame(9'd4, 256'hF, 4);
      n_cmp++;
      if (axon_out !== 256'hF || axon_valid !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_first got v=%0b b=%0b %h want 1 0 f",
                  axon_valid, busy, axon_out);
      end
      send_frame(9'd4, 256'h3, 4);
      tick();
      n_cmp++;
      if (axon_out !== 256'hF || busy !== 1'b1) begin
         n_err++;
         $display("FAIL bp_hold got b=%0b %h want 1 f", busy, axon_out);
      end
`ifdef SPIKE_COUNT_EN
      n_cmp++;
      if (spike_count !== 9'd4) begin
         n_err++;
         $display("FAIL bp_cnt_hold got %0d want 4", spike_count);
      end
`endif
      spike_valid = 1'b1;
      spike_in = 1'b1;
      tick();
      spike_valid = 1'b0;
      n_cmp++;
      if (overflow !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL bp_drop got o=%0b b=%0b want 1 1", overflow, busy);
      end
      axon_ready = 1'b1;
      tick();
      n_cmp++;
      if (axon_out !== 256'h3 || axon_valid !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bp_release got v=%0b b=%0b %h want 1 0 3",
                  axon_valid, busy, axon_out);
      end
`ifdef SPIKE_COUNT_EN
      n_cmp++;
      if (spike_count !== 9'd2) begin
         n_err++;
         $display("FAIL bp_cnt_rel got %0d want 2", spike_count);
      end
`endif
      tick();
      n_cmp++;
      if (axon_valid !== 1'b0 || axon_out !== 256'h3) begin
         n_err++;
         $display("FAIL bp_drain got v=%0b %h want 0 3", axon_valid, axon_out);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
   endtask

   task automatic test_abort();
      axon_ready = 1'b1;
      start = 1'b1;
      frame_len = 9'd4;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         spike_valid = 1'b1;
         spike_in = 1'b1;
         tick();
      end
      spike_valid = 1'b0;
      send_frame(9'd2, 256'b10, 2);
      n_cmp++;
      if (axon_out !== 256'h2 || axon_valid !== 1'b1) begin
         n_err++;
         $display("FAIL abort_vec got v=%0b %h want 1 2", axon_valid, axon_out);
      end
      tick();
   endtask

   task automatic test_idle_drop();
      spike_valid = 1'b1;
      spike_in = 1'b1;
      tick();
      n_cmp++;
      if (overflow !== 1'b1 || axon_valid !== 1'b0) begin
         n_err++;
         $display("FAIL idle_drop got o=%0b v=%0b want 1 0",
                  overflow, axon_valid);
      end
      clr_err = 1'b1;
      tick();
      n_cmp++;
      if (overflow !== 1'b1) begin
         n_err++;
         $display("FAIL clr_vs_drop got %0b want 1", overflow);
      end
      spike_valid = 1'b0;
      tick();
      clr_err = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL clr_err got %0b want 0", overflow);
      end
   endtask

   task automatic test_reset_mid_frame();
      axon_ready = 1'b0;
      send_frame(9'd3, 256'b101, 3);
      start = 1'b1;
      frame_len = '0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         spike_valid = 1'b1;
         spike_in = 1'b1;
         tick();
      end
      spike_valid = 1'b0;
      rstb = 1'b0;
      tick();
      n_cmp++;
      if (axon_valid !== 1'b0 || axon_out !== '0 ||
          busy !== 1'b0 || overflow !== 1'b0) begin
         n_err++;
         $display("FAIL midrst got v=%0b b=%0b o=%0b %h want 0 0 0 0",
                  axon_valid, busy, overflow, axon_out);
      end
      rstb = 1'b1;
      axon_ready = 1'b1;
      tick();
      send_frame(9'd5, 256'b11001, 5);
      n_cmp++;
      if (axon_out !== 256'h19 || axon_valid !== 1'b1) begin
         n_err++;
         $display("FAIL midrst_new got v=%0b %h want 1 19",
                  axon_valid, axon_out);
      end
      tick();
   endtask

   task automatic rtick();
      axon_ready = ($urandom % 3) != 0;
      tick();
   endtask

   task automatic test_random();
      logic [N-1:0] bits;
      logic [N-1:0] mask;
      logic [AW:0]  fl;
      int           eff;
      int           k;
      mon_en = 1'b1;
      for (int f = 0; f < 24; f++) begin
         if (f == 7)       fl = 9'd300;
         else if (f == 15) fl = 9'd0;
         else              fl = 9'($urandom_range(1, 40));
         eff = (fl == 0 || fl > N) ? N : int'(fl);
         for (int w = 0; w < N / 32; w++) bits[w*32 +: 32] = $urandom;
         mask = (eff == N) ? '1 : ((256'b1 << eff) - 256'b1);
         k = 0;
         while (busy && k < 2000) begin
            rtick();
            k++;
         end
         if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL rand_timeout got busy=1 want 0");
         end
         start = 1'b1;
         frame_len = fl;
         rtick();
         start = 1'b0;
         for (int i = 0; i < eff; i++) begin
            while ($urandom % 4 == 0) rtick();
            spike_valid = 1'b1;
            spike_in = bits[i];
            rtick();
            spike_valid = 1'b0;
         end
         exp_q.push_back(bits & mask);
      end
      axon_ready = 1'b1;
      k = 0;
      while ((axon_valid || busy) && k < 100) begin
         tick();
         k++;
      end
      tick();
      mon_en = 1'b0;
      n_cmp++;
      if (exp_q.size() != 0 || axon_valid !== 1'b0) begin
         n_err++;
         $display("FAIL rand_drain got left=%0d v=%0b want 0 0",
                  exp_q.size(), axon_valid);
      end
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++;
         $display("FAIL rand_ovf got %0b want 0", overflow);
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_short_frame();
      test_backpressure();
      test_abort();
      test_idle_drop();
      test_reset_mid_frame();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/spike_axon_collector.md
# spike_axon_collector

Core-side receiver for the 1-bit serialized axon spikes ejected by the tile spike crossbar on its core port. It deserializes a frame of up to NUM_AXONS spikes, one per strobe, into a parallel axon vector. It double-buffers that vector so the next frame can be collected while the neuron core consumes the previous one. It hands the vector to the core over a valid/ready handshake and flags spikes that arrive when no frame is open.

## Interface
- NUM_AXONS, 256, axon vector width = maximum frame length
- AXON_ADDR_WIDTH, 8, $clog2(NUM_AXONS); index width
- clk  input  1  clock, rising edge
- rstb  input  1  reset, synchronous, active-low
- start  input  1  open a new frame; samples frame_len
- frame_len  input  AXON_ADDR_WIDTH+1  spikes per frame; 0 or >NUM_AXONS treated as NUM_AXONS
- spike_valid  input  1  one spike present on spike_in this cycle
- spike_in  input  1  spike value (crossbar core-port output)
- axon_out  output  NUM_AXONS  completed axon vector; bit i = i-th spike of frame
- axon_valid  output  1  axon_out holds an unconsumed frame
- axon_ready  input  1  core accepts axon_out
- busy  output  1  frame open or frame waiting in shadow
- overflow  output  1  sticky: a spike_valid was dropped
- clr_err  input  1  clears overflow

## Operation
- Registers: shadow[NUM_AXONS], idx[AXON_ADDR_WIDTH+1], len_q, FSM state, output slot (axon_out, axon_valid).
- FSM IDLE: start -> clear shadow, idx=0, len_q=clamped frame_len, go COLLECT. spike_valid is dropped and sets overflow.
- FSM COLLECT: spike_valid writes shadow[idx]=spike_in and increments idx. start aborts the frame: shadow is cleared, idx=0, len_q is reloaded, and the state stays COLLECT.
- Frame completion: when the spike_valid with idx==len_q-1 is sampled, the completed frame, including that bit, goes to the output slot if the slot is free or is being freed by a handshake on the same edge; the FSM then returns to IDLE. Otherwise the frame stays in shadow and the FSM goes to HOLD.
- FSM HOLD: spike_valid is dropped and sets overflow; start is ignored. On the edge with axon_valid&&axon_ready, shadow moves to axon_out, axon_valid stays 1, and the FSM goes to IDLE.
- Handshake: axon_out is stable while axon_valid&&!axon_ready. On the handshake edge with no new frame, axon_valid clears and axon_out keeps its value.
- Bits of shadow at or above len_q are 0 in the delivered vector.
- busy = (state != IDLE).
- clr_err clears overflow. A drop on the same edge wins: overflow stays 1.

## Timing
- Reset values: axon_out=0, axon_valid=0, busy=0, overflow=0, spike_count=0, state=IDLE, idx=0.
- Latency: last spike sampled on edge E -> axon_valid=1 after edge E (visible in cycle E+1) when the slot is free.
- HOLD -> output: one edge after the handshake that frees the slot.
- Throughput: one spike per clock; back-to-back frames need one start cycle between them.
- Reset mid-frame discards shadow and the output slot.

## Configuration
- SPIKE_COUNT_EN defined:
  - adds output spike_count [AXON_ADDR_WIDTH:0], the number of 1 bits in the frame currently on axon_out;
  - counted incrementally during collection, transferred with the vector, held with it under backpressure;
  - reset to 0.
- SPIKE_COUNT_EN undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package spike_pkg: FSM state enum (IDLE, COLLECT, HOLD), NUM_AXONS and AXON_ADDR_WIDTH defaults, frame_len clamp function.
- No sub-module: shadow and output slot are two register arrays in one module.

## Test plan
- Frame at full length: reset, start with frame_len=0, then 256 spike_valid with spike_in=1 at even indices, axon_ready=1. Required: axon_valid=1 the cycle after the 256th spike; axon_out=0x5555…55; spike_count=128 if SPIKE_COUNT_EN is defined.
- Short frame: frame_len=4, spikes 1,0,1,1. Required: axon_out=0xD, upper bits 0, FSM back to IDLE, busy=0.
- Backpressure and HOLD: two 4-spike frames 0xF then 0x3 with axon_ready=0. Required:
  - axon_out stays 0xF and the FSM is in HOLD;
  - a spike_valid during HOLD sets overflow;
  - raising axon_ready gives axon_out=0x3 one edge later, then axon_valid=0 after the next handshake.
- Abort and restart: start, 3 spikes of 1, start again with frame_len=2, spikes 0,1. Required: axon_out=0x2 (the first frame is discarded).
- Drop in IDLE: spike_valid with no start. Required: overflow=1, axon_valid=0. Then clr_err and spike_valid on the same edge leaves overflow=1; clr_err alone clears it.
- Reset mid-frame: rstb=0 after 100 spikes. Required: all outputs at reset values; a new frame completes correctly.
